// File: rtl/pe_pkg.sv
// Shared widths and arithmetic helpers for the systolic MAC processing element.
package pe_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefAccW      = 24;
  localparam int unsigned DefFracShift = 4;
  localparam int unsigned PROD_W       = 2 * DefDataW;

  // Helpers work at a fixed wide width so callers can pass any ACC_W up to WideW-2.
  localparam int unsigned WideW = 64;
  typedef logic signed [WideW-1:0] wide_t;

  function automatic wide_t sat_signed(wide_t value, int unsigned width);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic wide_t round_shift(wide_t value, int unsigned shift);
    if (shift == 0) begin
      return value;
    end
    return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
  endfunction

endpackage

// File: rtl/pe_normalize.sv
// Rounds and shifts the accumulator down to DATA_W, clamping and flagging overflow.
module pe_normalize
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FRAC_SHIFT = DefFracShift
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  wide_t shifted;
  wide_t clamped;

  always_comb begin
    shifted = round_shift(wide_t'(acc_i), FRAC_SHIFT);
    clamped = sat_signed(shifted, DATA_W);
    y_o     = clamped[DATA_W-1:0];
    sat_o   = (clamped != shifted);
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic PE: forwards operands one hop per cycle and accumulates
// framed signed dot products into one normalised, saturated result each.
module systolic_mac_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned FRAC_SHIFT = DefFracShift
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_vld,
  output logic                     result_sat
);

  localparam int unsigned ProdW = 2 * DATA_W;

  if (ACC_W < ProdW) begin : g_acc_w_check
    $error("ACC_W must be at least 2*DATA_W");
  end
  if (FRAC_SHIFT >= ACC_W) begin : g_shift_check
    $error("FRAC_SHIFT must be below ACC_W");
  end
  if (ACC_W > WideW - 2) begin : g_wide_check
    $error("ACC_W exceeds helper arithmetic width");
  end

  // Forward path
  logic signed [DATA_W-1:0] a_q, b_q;
  logic                     vld_q, first_q, last_q;

  // Stage 1
  logic signed [ProdW-1:0] prod_d, prod_q;
  logic                    p_vld_q, p_first_q, p_last_q;

  // Stage 2 / result
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next, prod_ext, acc_sat;
  logic signed [ACC_W:0]    sum;
  wide_t                    sum_sat_w;
  logic                     clamp, sticky_q, sticky_d, sticky_next;
  logic signed [DATA_W-1:0] norm_y, result_q, result_d;
  logic                     norm_sat, result_vld_q, result_vld_d, result_sat_q, result_sat_d;

  assign prod_d = ProdW'(in_a) * ProdW'(in_b);

  always_comb begin
    prod_ext    = ACC_W'(prod_q);
    sum         = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(prod_q);
    sum_sat_w   = sat_signed(wide_t'(sum), ACC_W);
    acc_sat     = sum_sat_w[ACC_W-1:0];
    clamp       = !p_first_q && (sum_sat_w != wide_t'(sum));
    acc_next    = p_first_q ? prod_ext : acc_sat;
    sticky_next = (p_first_q ? 1'b0 : sticky_q) | clamp;
  end

  pe_normalize #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_norm (
    .acc_i (acc_next),
    .y_o   (norm_y),
    .sat_o (norm_sat)
  );

  always_comb begin
    acc_d        = acc_q;
    sticky_d     = sticky_q;
    result_d     = result_q;
    result_sat_d = result_sat_q;
    result_vld_d = 1'b0;
    if (p_vld_q) begin
      acc_d    = acc_next;
      sticky_d = sticky_next;
      if (p_last_q) begin
        result_d     = norm_y;
        result_sat_d = sticky_next | norm_sat;
        result_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      prod_q       <= '0;
      p_vld_q      <= 1'b0;
      p_first_q    <= 1'b0;
      p_last_q     <= 1'b0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      result_sat_q <= 1'b0;
    end else begin
      a_q          <= in_a;
      b_q          <= in_b;
      vld_q        <= in_valid;
      first_q      <= in_valid & in_first;
      last_q       <= in_valid & in_last;
      prod_q       <= prod_d;
      p_vld_q      <= in_valid;
      p_first_q    <= in_valid & in_first;
      p_last_q     <= in_valid & in_last;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      result_sat_q <= result_sat_d;
    end
  end

  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_valid  = vld_q;
  assign out_first  = first_q;
  assign out_last   = last_q;
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign result_sat = result_sat_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe with hand-computed dot-product results.
module tb_systolic_mac_pe;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] in_a, in_b, out_a, out_b, result;
  logic              in_valid, in_first, in_last;
  logic              out_valid, out_first, out_last, result_vld, result_sat;

  always #5 clk = ~clk;

  systolic_mac_pe #(
    .DATA_W     (8),
    .ACC_W      (24),
    .FRAC_SHIFT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .result     (result),
    .result_vld (result_vld),
    .result_sat (result_sat)
  );

  int n_total = 0;
  int n_bad   = 0;
  int res_q[$];
  int sat_q[$];
  bit vld_in_reset = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Collect every result pulse away from the active edge.
  always @(negedge clk) begin
    if (result_vld) begin
      if (!reset) vld_in_reset = 1'b1;
      res_q.push_back(int'(result));
      sat_q.push_back(int'(result_sat));
    end
  end

  // Apply one cycle of input and check the forwarded copy after the edge.
  task automatic beat(input int a, input int b, input bit v, input bit f, input bit l);
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_valid = v;
    in_first = f;
    in_last  = l;
    @(posedge clk);
    #1;
    check("out_a", int'(out_a), a);
    check("out_b", int'(out_b), b);
    check("out_valid", int'(out_valid), int'(v));
    check("out_first", int'(out_first), int'(v & f));
    check("out_last", int'(out_last), int'(v & l));
  endtask

  // Invalid cycle with random operands and flags that must be ignored.
  task automatic bubble();
    beat($urandom_range(255) - 128, $urandom_range(255) - 128, 1'b0,
         1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) bubble();
  endtask

  task automatic expect_one(input string tag, input int exp_res, input int exp_sat);
    check({tag, "_count"}, res_q.size(), 1);
    check({tag, "_result"}, (res_q.size() > 0) ? res_q[0] : -999, exp_res);
    check({tag, "_sat"}, (sat_q.size() > 0) ? sat_q[0] : -999, exp_sat);
  endtask

  task automatic clear();
    res_q.delete();
    sat_q.delete();
  endtask

  initial begin
    // 1: reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_valid = 1'($urandom);
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk);
    end
    #1;
    check("rst_out_a", int'(out_a), 0);
    check("rst_out_b", int'(out_b), 0);
    check("rst_out_flags", int'({out_valid, out_first, out_last}), 0);
    check("rst_result", int'(result), 0);
    check("rst_result_flags", int'({result_vld, result_sat}), 0);
    check("rst_vld_count", res_q.size(), 0);
    reset = 1'b1;
    drain();
    clear();

    // 2: back-to-back product with latency check
    beat(2, 3, 1'b1, 1'b1, 1'b0);
    beat(-4, 5, 1'b1, 1'b0, 1'b0);
    beat(7, 7, 1'b1, 1'b0, 1'b1);
    check("t2_vld_edge0", int'(result_vld), 0);
    beat(0, 0, 1'b0, 1'b0, 1'b0);
    check("t2_vld_edge1", int'(result_vld), 1);
    check("t2_result_edge1", int'(result), 2);
    beat(0, 0, 1'b0, 1'b0, 1'b0);
    check("t2_vld_edge2", int'(result_vld), 0);
    check("t2_result_hold", int'(result), 2);
    drain();
    expect_one("t2", 2, 0);
    clear();

    // 3: same product with random bubbles
    for (int rep = 0; rep < 3; rep++) begin
      beat(2, 3, 1'b1, 1'b1, 1'b0);
      for (int g = $urandom_range(3); g > 0; g--) bubble();
      beat(-4, 5, 1'b1, 1'b0, 1'b0);
      for (int g = $urandom_range(3); g > 0; g--) bubble();
      beat(7, 7, 1'b1, 1'b0, 1'b1);
      drain();
      expect_one("t3", 2, 0);
      clear();
    end

    // 4a: ten max products, normaliser clamps
    for (int i = 0; i < 10; i++) beat(127, 127, 1'b1, i == 0, i == 9);
    drain();
    expect_one("t4a", 127, 1);
    clear();

    // 4b: accumulator clamps at +8388607
    for (int i = 0; i < 600; i++) beat(-128, -128, 1'b1, i == 0, i == 599);
    drain();
    expect_one("t4b", 127, 1);
    clear();

    // 5: single-term product then back-to-back two-term product
    beat(-3, 5, 1'b1, 1'b1, 1'b1);
    beat(1, 1, 1'b1, 1'b1, 1'b0);
    beat(1, 1, 1'b1, 1'b0, 1'b1);
    drain();
    check("t5_count", res_q.size(), 2);
    check("t5_res0", (res_q.size() > 0) ? res_q[0] : -999, -1);
    check("t5_sat0", (sat_q.size() > 0) ? sat_q[0] : -999, 0);
    check("t5_res1", (res_q.size() > 1) ? res_q[1] : -999, 0);
    check("t5_sat1", (sat_q.size() > 1) ? sat_q[1] : -999, 0);
    clear();

    // 6: reset mid-product discards the partial sum
    beat(100, 100, 1'b1, 1'b1, 1'b0);
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_out_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    beat(2, 3, 1'b1, 1'b1, 1'b0);
    beat(-4, 5, 1'b1, 1'b0, 1'b0);
    beat(7, 7, 1'b1, 1'b0, 1'b1);
    drain();
    expect_one("t6", 2, 0);
    check("vld_during_reset", int'(vld_in_reset), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
